snake_vga_tile_renderer: RTL and testbench
==========================================

# snake_vga_tile_renderer

Parametrised VGA timing generator and tile renderer for the snake game display path. It produces HS/VS and 12-bit RGB from a grid of multi-bit tiles. Each tile is a palette index, and each display row of tiles is fetched once per scanline through a request/data handshake with the game-state block. Border tiles are drawn in hardware, and every timing value, the tile size, the grid size and the colour depth are parameters.

## Interface
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, HS pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, VS pulse width (lines)
- V_BP, 29, vertical back porch (lines)
- TILE_LOG2, 4, log2 of tile edge in pixels (16×16 tiles)
- COLS, 40, tiles per row
- ROWS, 30, tile rows
- BPP, 2, bits per tile, used as the palette index
- BORDER, 1, 1 forces the outer ring of tiles to palette entry 2**BPP-1
- clk_25MHz  in  1  pixel clock
- rst_n  in  1  synchronous, active-low reset
- row_data  in  COLS*BPP  tile row; tile c is at [c*BPP +: BPP]
- palette  in  12*2**BPP  entry k is at [12k +: 12]; bits {R[3:0],G[3:0],B[3:0]}
- row_req  out  1  one-cycle pulse requesting row row_idx
- row_idx  out  clog2(ROWS)  tile row being requested
- frame_start  out  1  one-cycle pulse at the start of each frame
- VGA_HS  out  1  horizontal sync, active low
- VGA_VS  out  1  vertical sync, active low
- VGA_R, VGA_G, VGA_B  out  4 each  pixel colour

## Operation
- **Counters and derived constants**
  - H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP and V_TOTAL = V_SYNC+V_BP+V_ACTIVE+V_FP.
  - Region order is sync, back porch, active, front porch.
  - H_START = H_SYNC+H_BP and V_START = V_SYNC+V_BP.
  - h_cnt counts 0..H_TOTAL-1. v_cnt advances when h_cnt wraps and itself wraps at V_TOTAL-1.
- **Active region**
  - A pixel is active when H_START ≤ h_cnt < H_START+H_ACTIVE and V_START ≤ v_cnt < V_START+V_ACTIVE.
  - x = h_cnt-H_START, y = v_cnt-V_START, col = x>>TILE_LOG2, row = y>>TILE_LOG2.
- **Row fetch**
  - At h_cnt==0 on an active line, row_req pulses for one cycle and row_idx = row.
  - row_idx holds its value until the next request.
  - row_data is captured into an internal line register at h_cnt==H_SYNC. The provider therefore has H_SYNC cycles to respond.
  - row_data is don't-care at all other times.
- **Pixel colour**
  - idx = line_reg[col*BPP +: BPP].
  - If BORDER and (col==0 or col==COLS-1 or row==0 or row==ROWS-1), idx = 2**BPP-1.
  - Output colour = palette[idx].
  - Inactive pixels, and pixels with col ≥ COLS or row ≥ ROWS, output RGB 0.
- **Sync signals**
  - VGA_HS = 0 while h_cnt < H_SYNC.
  - VGA_VS = 0 while v_cnt < V_SYNC.
- **frame_start** pulses when h_cnt==0 and v_cnt==0.
- Arithmetic is unsigned. The counter width is clog2 of the total.

## Timing
- **Output registration**
  - Every output is registered.
  - HS, VS, RGB, row_req, row_idx and frame_start all reflect the counter state of the previous cycle, so they are mutually aligned with 1-cycle latency.
- **Reset** (rst_n low at an edge)
  - h_cnt=0, v_cnt=0, line_reg=0.
  - VGA_HS=1, VGA_VS=1, RGB=0, row_req=0, row_idx=0, frame_start=0.
- **After reset**
  - The first edge with rst_n high registers the outputs for h_cnt=0, v_cnt=0: HS goes 0, VS goes 0, frame_start goes 1.
- **Reset mid-frame**: the next cycle shows the reset values above, and the frame restarts from (0,0). There is no partial line.
- **Input sampling**
  - palette is sampled combinationally every pixel. A change takes effect on the next output edge.
  - row_data changes after the capture point do not affect the current line.
- **Default-parameter figures**: 800 cycles/line, 521 lines/frame, 416 800 cycles/frame.
- **Frame wrap**: h_cnt 799 → 0 and v_cnt 520 → 0 occur on the same edge.

## Test plan
- **Reset**
  - Stimulus: hold rst_n=0 for 5 cycles, then release.
  - Required: during reset HS=1, VS=1, RGB=0, row_req=0. On the first edge after release, HS=0, VS=0, frame_start=1.
- **Sync timing**
  - Stimulus: run two frames.
  - Required:
    - HS period 800 cycles, low for exactly 96.
    - VS low for exactly 1600 cycles every 416 800.
    - frame_start spacing 416 800.
- **Row fetch**
  - Stimulus: run one frame.
  - Required:
    - Exactly 480 row_req pulses, on lines 31..510.
    - row_idx steps 0..29, each value held for 16 consecutive requests.
    - No row_req on lines 0..30 or 511..520.
- **Pixel mapping**
  - Stimulus: palette entry 2 = 12'hF00, entry 0 = 12'h000; row_data with tile 5 = 2'b10 and all other tiles 0; observe line 50.
  - Required: RGB = F,0,0 for the 16 cycles aligned to h_cnt 224..239 and 0 elsewhere in the active region.
- **Border**
  - Stimulus: BORDER=1, all row_data 0, palette entry 3 = 12'hFFF.
  - Required:
    - Tile col 0 (h_cnt 144..159) and col 39 (h_cnt 768..783) are white on every active line.
    - Lines 31..46 and 495..510 are fully white.
    - Blanking is 0.
- **Mid-frame reset**
  - Stimulus: assert rst_n=0 for 1 cycle at v_cnt=200, h_cnt=400.
  - Required: outputs take their reset values, then follow exactly the sequence of the reset test.

Source files
------------

// File: rtl/snake_vga_tile_renderer.sv
// VGA timing generator and tile renderer for the snake display path.
// Fetches one row of palette-indexed tiles per scanline and draws a hardware border.
module snake_vga_tile_renderer #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 29,
    parameter int unsigned TILE_LOG2 = 4,
    parameter int unsigned COLS      = 40,
    parameter int unsigned ROWS      = 30,
    parameter int unsigned BPP       = 2,
    parameter int unsigned BORDER    = 1
) (
    input  logic                        clk_25MHz,
    input  logic                        rst_n,
    input  logic [COLS*BPP-1:0]         row_data,
    input  logic [12*(2**BPP)-1:0]      palette,
    output logic                        row_req,
    output logic [$clog2(ROWS)-1:0]     row_idx,
    output logic                        frame_start,
    output logic                        VGA_HS,
    output logic                        VGA_VS,
    output logic [3:0]                  VGA_R,
    output logic [3:0]                  VGA_G,
    output logic [3:0]                  VGA_B
);

    localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);
    localparam int unsigned RIW     = $clog2(ROWS);
    localparam int unsigned NPAL    = 2 ** BPP;

    localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_SYNC_C  = HW'(H_SYNC);
    localparam logic [HW-1:0] H_START_C = HW'(H_SYNC + H_BP);
    localparam logic [HW-1:0] H_END_C   = HW'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_SYNC_C  = VW'(V_SYNC);
    localparam logic [VW-1:0] V_START_C = VW'(V_SYNC + V_BP);
    localparam logic [VW-1:0] V_END_C   = VW'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [HW-1:0] COLS_C    = HW'(COLS);
    localparam logic [HW-1:0] COL_LAST  = HW'(COLS - 1);
    localparam logic [VW-1:0] ROWS_C    = VW'(ROWS);
    localparam logic [VW-1:0] ROW_LAST  = VW'(ROWS - 1);

    logic [HW-1:0]       h_cnt;
    logic [VW-1:0]       v_cnt;
    logic [COLS*BPP-1:0] line_reg;

    logic                h_act;
    logic                v_act;
    logic [HW-1:0]       x;
    logic [VW-1:0]       y;
    logic [HW-1:0]       col;
    logic [VW-1:0]       row;
    logic                border_tile;
    logic [BPP-1:0]      tile_idx;
    logic [11:0]         colour;
    logic [11:0]         pix;

    always_comb begin
        h_act = (h_cnt >= H_START_C) && (h_cnt < H_END_C);
        v_act = (v_cnt >= V_START_C) && (v_cnt < V_END_C);
        x     = h_cnt - H_START_C;
        y     = v_cnt - V_START_C;
        col   = x >> TILE_LOG2;
        row   = y >> TILE_LOG2;
    end

    always_comb begin
        tile_idx = '0;
        for (int c = 0; c < COLS; c++) begin
            if (col == HW'(c)) begin
                tile_idx = line_reg[c*BPP +: BPP];
            end
        end

        border_tile = (col == '0) || (col == COL_LAST) || (row == '0) || (row == ROW_LAST);
        if ((BORDER != 0) && border_tile) begin
            tile_idx = '1;
        end

        colour = '0;
        for (int k = 0; k < NPAL; k++) begin
            if (tile_idx == BPP'(k)) begin
                colour = palette[12*k +: 12];
            end
        end

        // Columns/rows past the tile grid stay black even inside the active area.
        pix = (h_act && v_act && (col < COLS_C) && (row < ROWS_C)) ? colour : 12'h000;
    end

    always_ff @(posedge clk_25MHz) begin
        if (!rst_n) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            line_reg    <= '0;
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_R       <= 4'h0;
            VGA_G       <= 4'h0;
            VGA_B       <= 4'h0;
            row_req     <= 1'b0;
            row_idx     <= '0;
            frame_start <= 1'b0;
        end else begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end

            // The provider gets the whole sync pulse to answer a request.
            if (h_cnt == H_SYNC_C) begin
                line_reg <= row_data;
            end

            VGA_HS                <= (h_cnt >= H_SYNC_C);
            VGA_VS                <= (v_cnt >= V_SYNC_C);
            frame_start           <= (h_cnt == '0) && (v_cnt == '0);
            row_req               <= (h_cnt == '0) && v_act;
            if ((h_cnt == '0) && v_act) begin
                row_idx <= RIW'(row);
            end
            {VGA_R, VGA_G, VGA_B} <= pix;
        end
    end

endmodule

// File: tb/tb_snake_vga_tile_renderer.sv
// Scoreboard bench for snake_vga_tile_renderer on a scaled-down timing set:
// 80 cycles/line (sync 8, bp 4, active 64, fp 4), 55 lines/frame (2, 3, 48, 2), 8x6 tiles of 8 px.
module tb_snake_vga_tile_renderer;

    localparam int HT    = 80;
    localparam int VT    = 55;
    localparam int FT    = HT * VT;   // 4400
    localparam int HSW   = 8;
    localparam int HST   = 12;        // first active h_cnt
    localparam int HEN   = 76;
    localparam int VSW   = 2;
    localparam int VST   = 5;         // first active line
    localparam int VEN   = 53;

    localparam logic [47:0] PAL_BORDER = {12'hFFF, 12'hF00, 12'h0F0, 12'h000};
    localparam logic [47:0] PAL_PIX    = {12'h000, 12'hF00, 12'h0F0, 12'h000};

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] row_data;
    logic [47:0] palette;
    logic        row_req;
    logic [2:0]  row_idx;
    logic        frame_start;
    logic        VGA_HS;
    logic        VGA_VS;
    logic [3:0]  VGA_R;
    logic [3:0]  VGA_G;
    logic [3:0]  VGA_B;

    snake_vga_tile_renderer #(
        .H_ACTIVE (64),
        .H_FP     (4),
        .H_SYNC   (8),
        .H_BP     (4),
        .V_ACTIVE (48),
        .V_FP     (2),
        .V_SYNC   (2),
        .V_BP     (3),
        .TILE_LOG2(3),
        .COLS     (8),
        .ROWS     (6),
        .BPP      (2),
        .BORDER   (1)
    ) dut (
        .clk_25MHz  (clk),
        .rst_n      (rst_n),
        .row_data   (row_data),
        .palette    (palette),
        .row_req    (row_req),
        .row_idx    (row_idx),
        .frame_start(frame_start),
        .VGA_HS     (VGA_HS),
        .VGA_VS     (VGA_VS),
        .VGA_R      (VGA_R),
        .VGA_G      (VGA_G),
        .VGA_B      (VGA_B)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned at;
        int          sel;
        logic [11:0] exp;
    } exp_t;

    exp_t        sb[$];
    int unsigned gcyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          ri_model = 0;
    logic [15:0] pat = 16'h0000;
    string       names[6] = '{"hs", "vs", "rgb", "row_req", "row_idx", "frame_start"};

    always @(posedge clk) gcyc <= gcyc + 1;

    task automatic push(input int unsigned at, input int sel, input logic [11:0] v);
        exp_t e;
        e.at  = at;
        e.sel = sel;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic push_reset(input int unsigned at);
        push(at, 0, 12'd1);
        push(at, 1, 12'd1);
        push(at, 2, 12'd0);
        push(at, 3, 12'd0);
        push(at, 4, 12'd0);
        push(at, 5, 12'd0);
    endtask

    function automatic logic [11:0] exp_rgb(input int mode, input int h, input int v);
        int col;
        int row;
        bit brd;
        if (h < HST || h >= HEN || v < VST || v >= VEN) return 12'h000;
        col = (h - HST) / 8;
        row = (v - VST) / 8;
        brd = (col == 0) || (col == 7) || (row == 0) || (row == 5);
        if (mode == 0) return brd ? 12'hFFF : 12'h000;
        return (!brd && col == 5) ? 12'hF00 : 12'h000;
    endfunction

    // Expected outputs for npos positions starting at (0,0), first sampled at global cycle base.
    task automatic gen(input int unsigned base, input int npos, input int mode);
        for (int p = 0; p < npos; p++) begin
            int h;
            int v;
            bit rr;
            h  = p % HT;
            v  = (p / HT) % VT;
            rr = (h == 0) && (v >= VST) && (v < VEN);
            if (rr) ri_model = (v - VST) / 8;
            push(base + p, 0, {11'd0, h >= HSW});
            push(base + p, 1, {11'd0, v >= VSW});
            push(base + p, 2, exp_rgb(mode, h, v));
            push(base + p, 3, {11'd0, rr});
            push(base + p, 4, 12'(ri_model));
            push(base + p, 5, {11'd0, (h == 0) && (v == 0)});
        end
    endtask

    // Row provider: valid data only through the capture edge, garbage afterwards.
    always @(negedge clk) begin
        if (row_req === 1'b1) begin
            row_data = pat;
            repeat (HSW) @(posedge clk);
            #1 row_data = 16'hFFFF;
        end
    end

    // Monitor: every cycle the DUT presents a full output set; pop what is due.
    always @(negedge clk) begin
        while (sb.size() != 0 && sb[0].at <= gcyc) begin
            exp_t        e;
            logic [11:0] act;
            e = sb.pop_front();
            case (e.sel)
                0:       act = {11'd0, VGA_HS};
                1:       act = {11'd0, VGA_VS};
                2:       act = {VGA_R, VGA_G, VGA_B};
                3:       act = {11'd0, row_req};
                4:       act = {9'd0, row_idx};
                default: act = {11'd0, frame_start};
            endcase
            checks++;
            if (e.at != gcyc || act !== e.exp) begin
                failures++;
                $display("FAIL %s cyc=%0d due=%0d actual=%0h required=%0h",
                         names[e.sel], gcyc, e.at, act, e.exp);
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        row_data = 16'hFFFF;
        palette  = PAL_BORDER;
        pat      = 16'h0000;

        for (int unsigned c = 1; c <= 5; c++) push_reset(c);
        ri_model = 0;
        gen(6, FT, 0);        // frame 1: border pattern, empty rows
        gen(6 + FT, FT, 1);   // frame 2: tile 5 = index 2, red

        repeat (5) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // Switch to the pixel-mapping setup in the vertical blanking of frame 1.
        while (gcyc < 4300) @(negedge clk);
        palette = PAL_PIX;
        pat     = 16'h0800;

        // Next edge processes v=20, h=40 of frame 3.
        while (gcyc < 10445) @(negedge clk);
        rst_n    = 1'b0;
        push_reset(10446);
        ri_model = 0;
        gen(10447, 2 * HT, 0);
        @(negedge clk) rst_n = 1'b1;

        while (gcyc < 10447 + 2 * HT + 2) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d pending required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
